branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch unit for the RV32 pipeline. It combines a fetch-stage predictor (a bimodal table of 2-bit counters plus a tagged target buffer) with execute-stage branch resolution. Resolution covers all six conditional branches with correct signed and unsigned compares, plus JAL and JALR. Each resolved control-flow instruction trains the tables and produces a registered redirect/flush pulse when the prediction was wrong.

## Interface
- XLEN, 32: datapath and PC width.
- BHT_DEPTH, 64: entries in the counter table and the target buffer; power of two, at least 4. IDX_W = log2(BHT_DEPTH).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_pc_in  in  XLEN  PC being fetched.
- predict_taken_out  out  1  predict redirect at fetch (combinational).
- predict_target_out  out  XLEN  predicted target (combinational).
- exec_valid_in  in  1  execute-stage instruction valid.
- opcode  in  7  execute-stage opcode.
- funct3  in  3  execute-stage funct3.
- pc_in  in  XLEN  execute-stage PC.
- rs1_value_in, rs2_value_in, imm_value_in  in  XLEN  operands and sign-extended immediate.
- pred_taken_in  in  1  prediction that travelled down the pipe with this instruction.
- pred_target_in  in  XLEN  predicted target that travelled with it.
- pc_out  out  XLEN  correct next PC, registered.
- branch_mispredicted_out  out  1  one-cycle redirect/flush pulse, registered.

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[XLEN-1:IDX_W+2].
- Each entry holds a 2-bit counter, a valid bit, a tag and a target.
- Lookup:
  - hit = valid and tag match on fetch_pc_in.
  - predict_taken_out = hit and counter[1].
  - predict_target_out = stored target when hit, otherwise fetch_pc_in+4.
- Resolution, evaluated only when exec_valid_in=1:
  - opcode 1100011 (conditional branch), by funct3:
    - 000 BEQ; 001 BNE.
    - 100 BLT and 101 BGE use signed compare.
    - 110 BLTU and 111 BGEU use unsigned compare.
    - 010 and 011 are treated as never taken.
    - target = pc_in+imm.
  - opcode 1101111 (JAL): always taken, target = pc_in+imm.
  - opcode 1100111 (JALR): always taken, target = (rs1+imm) with bit 0 cleared.
  - Any other opcode: not taken.
- All sums are modulo 2^XLEN.
- Next PC = target if taken, else pc_in+4.
- Mispredict when either:
  - taken differs from pred_taken_in, or
  - taken and pred_taken_in are both 1 and target differs from pred_target_in.
- Training, performed on the table entry at pc_in:
  - Conditional branch:
    - counter increments (saturating at 11) if taken, decrements (saturating at 00) if not.
    - if taken, also write tag and target and set valid.
    - if not taken and the entry is invalid, nothing is written.
  - JAL/JALR: write tag and target, set valid, force counter to 11.
  - Other opcode with pred_taken_in=1 (stale alias): clear valid; a mispredict is still raised, with pc_out = pc_in+4.
  - Other opcode with pred_taken_in=0: no write, no pulse.
- Tag mismatch on a conditional branch replaces the entry: new tag, counter 10 if taken; if not taken the entry is left untouched.

## Timing
- Lookup is combinational from table registers. There is no bypass: a training write and a lookup of the same index in one cycle return the pre-write contents.
- Resolution latency is 1 cycle. pc_out and branch_mispredicted_out update on the edge after exec_valid_in.
  - branch_mispredicted_out is high for exactly one cycle per mispredict.
  - pc_out holds its value until the next valid resolution.
- Back-to-back valid resolutions are accepted every cycle. Each produces its own pulse and its own table write.
- Reset, effective on the clock edge while asserted:
  - all counters = 01 (weakly not taken), all valid = 0;
  - pc_out = 0, branch_mispredicted_out = 0, statistics counters = 0.
- Reset mid-operation discards any pending pulse and ignores exec_valid_in during reset cycles.

## Configuration
- BRANCH_STATS_EN defined:
  - adds outputs stat_branches_out (32 bits) and stat_mispredicts_out (32 bits), both registered.
  - counts, respectively, resolved control-flow instructions (branch, JAL, JALR with exec_valid_in=1) and raised mispredicts.
  - both counters saturate at 0xFFFFFFFF.
- BRANCH_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- After reset, fetch_pc_in=0x100 gives predict_taken_out=0 and predict_target_out=0x104; all outputs are 0.
- BEQ at 0x100 with rs1=rs2=5, imm=0x40, pred_taken_in=0:
  - next cycle: pc_out=0x140 and a one-cycle mispredict pulse;
  - afterwards, a lookup of 0x100 gives taken=1 with target 0x140 (counter 10).
- BLT with rs1=0xFFFFFFFF, rs2=1 is taken. BLTU with the same operands is not taken: pc_out=pc_in+4, and no pulse when pred_taken_in=0.
- JALR with rs1=0x2001, imm=2, pred_taken_in=1, pred_target_in=0x2002:
  - target is 0x2002, so there is no mispredict;
  - rerun with pred_target_in=0x3000: pulse raised, pc_out=0x2002.
- Train the BEQ at 0x100 taken twice (counter 11), then resolve it not-taken twice: the lookup flips to not-taken only after the second resolution (counter 01).
- Assert reset in the cycle right after a mispredicting resolution: no pulse appears, and the table returns to the all-01, all-invalid state.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolution signals of the branch unit.
// Stat outputs exist only when BRANCH_STATS_EN is defined.
interface branch_predict_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] fetch_pc_in;
   logic            predict_taken_out;
   logic [XLEN-1:0] predict_target_out;
   logic            exec_valid_in;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] pc_in;
   logic [XLEN-1:0] rs1_value_in;
   logic [XLEN-1:0] rs2_value_in;
   logic [XLEN-1:0] imm_value_in;
   logic            pred_taken_in;
   logic [XLEN-1:0] pred_target_in;
   logic [XLEN-1:0] pc_out;
   logic            branch_mispredicted_out;
`ifdef BRANCH_STATS_EN
   logic [31:0]     stat_branches_out;
   logic [31:0]     stat_mispredicts_out;
`endif

   modport slave (
      input  fetch_pc_in, exec_valid_in, opcode, funct3, pc_in,
             rs1_value_in, rs2_value_in, imm_value_in, pred_taken_in, pred_target_in,
`ifdef BRANCH_STATS_EN
      output stat_branches_out, stat_mispredicts_out,
`endif
      output predict_taken_out, predict_target_out, pc_out, branch_mispredicted_out
   );

   modport master (
      output fetch_pc_in, exec_valid_in, opcode, funct3, pc_in,
             rs1_value_in, rs2_value_in, imm_value_in, pred_taken_in, pred_target_in,
`ifdef BRANCH_STATS_EN
      input  stat_branches_out, stat_mispredicts_out,
`endif
      input  predict_taken_out, predict_target_out, pc_out, branch_mispredicted_out
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal + tagged-target fetch predictor with 1-cycle execute resolution/training.
// Optional statistics counters under BRANCH_STATS_EN.
module branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64
) (
   input logic                 clk,
   input logic                 reset,
   branch_predict_unit_if.slave bp
);
   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [1:0]           cnt_q [BHT_DEPTH];
   logic [BHT_DEPTH-1:0] vld_q;
   logic [TAG_W-1:0]     tag_q [BHT_DEPTH];
   logic [XLEN-1:0]      tgt_q [BHT_DEPTH];

   logic [XLEN-1:0] pc_q;
   logic            mis_q;

   // Fetch lookup, no bypass from the training write
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   assign f_idx = bp.fetch_pc_in[IDX_W+1:2];
   assign f_tag = bp.fetch_pc_in[XLEN-1:IDX_W+2];
   assign f_hit = vld_q[f_idx] && (tag_q[f_idx] == f_tag);

   assign bp.predict_taken_out  = f_hit && cnt_q[f_idx][1];
   assign bp.predict_target_out = f_hit ? tgt_q[f_idx] : bp.fetch_pc_in + XLEN'(4);

   logic [IDX_W-1:0] e_idx;
   logic [TAG_W-1:0] e_tag;
   logic             e_hit;
   logic             is_br, is_jmp;
   logic             br_taken, taken_d;
   logic [XLEN-1:0]  jalr_sum, target_d, next_pc_d;
   logic             mis_d;

   assign e_idx    = bp.pc_in[IDX_W+1:2];
   assign e_tag    = bp.pc_in[XLEN-1:IDX_W+2];
   assign e_hit    = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign is_br    = (bp.opcode == OP_BRANCH);
   assign is_jmp   = (bp.opcode == OP_JAL) || (bp.opcode == OP_JALR);
   assign jalr_sum = bp.rs1_value_in + bp.imm_value_in;

   always_comb begin
      br_taken = 1'b0;
      unique case (bp.funct3)
         3'b000:  br_taken = (bp.rs1_value_in == bp.rs2_value_in);
         3'b001:  br_taken = (bp.rs1_value_in != bp.rs2_value_in);
         3'b100:  br_taken = ($signed(bp.rs1_value_in) <  $signed(bp.rs2_value_in));
         3'b101:  br_taken = ($signed(bp.rs1_value_in) >= $signed(bp.rs2_value_in));
         3'b110:  br_taken = (bp.rs1_value_in <  bp.rs2_value_in);
         3'b111:  br_taken = (bp.rs1_value_in >= bp.rs2_value_in);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      taken_d  = (is_br && br_taken) || is_jmp;
      target_d = (bp.opcode == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                        : bp.pc_in + bp.imm_value_in;
      next_pc_d = taken_d ? target_d : bp.pc_in + XLEN'(4);
      mis_d = bp.exec_valid_in &&
              ((taken_d != bp.pred_taken_in) ||
               (taken_d && bp.pred_taken_in && (target_d != bp.pred_target_in)));
   end

   // Training decision for the entry at pc_in
   logic       cnt_we, ent_we, vld_clr;
   logic [1:0] cnt_d;

   always_comb begin
      cnt_we  = 1'b0;
      ent_we  = 1'b0;
      vld_clr = 1'b0;
      cnt_d   = cnt_q[e_idx];
      if (bp.exec_valid_in) begin
         if (is_br) begin
            if (e_hit) begin
               cnt_we = 1'b1;
               ent_we = taken_d;
               if (taken_d)
                  cnt_d = (cnt_q[e_idx] == 2'b11) ? 2'b11 : cnt_q[e_idx] + 2'd1;
               else
                  cnt_d = (cnt_q[e_idx] == 2'b00) ? 2'b00 : cnt_q[e_idx] - 2'd1;
            end else if (taken_d) begin
               // Miss (invalid or alias) starts the new owner weakly taken
               cnt_we = 1'b1;
               ent_we = 1'b1;
               cnt_d  = 2'b10;
            end
         end else if (is_jmp) begin
            cnt_we = 1'b1;
            ent_we = 1'b1;
            cnt_d  = 2'b11;
         end else if (bp.pred_taken_in) begin
            vld_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= 2'b01;
         vld_q <= '0;
         pc_q  <= '0;
         mis_q <= 1'b0;
      end else begin
         if (cnt_we) cnt_q[e_idx] <= cnt_d;
         if (ent_we)       vld_q[e_idx] <= 1'b1;
         else if (vld_clr) vld_q[e_idx] <= 1'b0;
         if (bp.exec_valid_in) pc_q <= next_pc_d;
         mis_q <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && ent_we) begin
         tag_q[e_idx] <= e_tag;
         tgt_q[e_idx] <= target_d;
      end
   end

   assign bp.pc_out                  = pc_q;
   assign bp.branch_mispredicted_out = mis_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_br_q, stat_mis_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         if (bp.exec_valid_in && (is_br || is_jmp) && (stat_br_q != 32'hFFFF_FFFF))
            stat_br_q <= stat_br_q + 32'd1;
         if (mis_d && (stat_mis_q != 32'hFFFF_FFFF))
            stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   assign bp.stat_branches_out    = stat_br_q;
   assign bp.stat_mispredicts_out = stat_mis_q;
`endif

   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{bp.fetch_pc_in[1:0], bp.pc_in[1:0]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: expected pc_out/pulse queued at issue, popped one cycle later.
module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.XLEN(32)) bp ();
   branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (.clk(clk), .reset(reset), .bp(bp));

   typedef struct packed {
      logic [31:0] pc;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int errors = 0;
   int checks = 0;

   function automatic exp_t mk(input logic [31:0] pc, input logic mis);
      exp_t r;
      r.pc  = pc;
      r.mis = mis;
      return r;
   endfunction

   // Reference resolution model
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] pc, rs1, rs2, imm,
                                  input logic pt, input logic [31:0] ptgt);
      logic tk;
      logic [31:0] tg;
      exp_t r;
      tk = 1'b0;
      tg = pc + imm;
      if (op == 7'h63) begin
         case (f3)
            3'd0: tk = (rs1 == rs2);
            3'd1: tk = (rs1 != rs2);
            3'd4: tk = ($signed(rs1) < $signed(rs2));
            3'd5: tk = !($signed(rs1) < $signed(rs2));
            3'd6: tk = (rs1 < rs2);
            3'd7: tk = !(rs1 < rs2);
            default: tk = 1'b0;
         endcase
      end else if (op == 7'h6f) begin
         tk = 1'b1;
      end else if (op == 7'h67) begin
         tk = 1'b1;
         tg = (rs1 + imm) & 32'hFFFF_FFFE;
      end
      r.pc  = tk ? tg : pc + 32'd4;
      r.mis = (tk != pt) || (tk && pt && (tg != ptgt));
      return r;
   endfunction

   task automatic idle();
      bp.exec_valid_in  = 1'b0;
      bp.opcode         = 7'h13;
      bp.funct3         = 3'd0;
      bp.pc_in          = 32'h0;
      bp.rs1_value_in   = 32'h0;
      bp.rs2_value_in   = 32'h0;
      bp.imm_value_in   = 32'h0;
      bp.pred_taken_in  = 1'b0;
      bp.pred_target_in = 32'h0;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, rs1, rs2, imm,
                        input logic pt, input logic [31:0] ptgt);
      bp.exec_valid_in  = 1'b1;
      bp.opcode         = op;
      bp.funct3         = f3;
      bp.pc_in          = pc;
      bp.rs1_value_in   = rs1;
      bp.rs2_value_in   = rs2;
      bp.imm_value_in   = imm;
      bp.pred_taken_in  = pt;
      bp.pred_target_in = ptgt;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      bp.fetch_pc_in = 32'h100;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      checks++; if (bp.predict_taken_out !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", bp.predict_taken_out); end
      checks++; if (bp.predict_target_out !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h want 00000104", bp.predict_target_out); end
      checks++; if (bp.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", bp.pc_out); end
      checks++; if (bp.branch_mispredicted_out !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", bp.branch_mispredicted_out); end
   endtask

   task automatic test_beq();
      issue(7'h63, 3'd0, 32'h100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
      sb.push_back(mk(32'h140, 1'b1));
      @(negedge clk); idle();
      e = sb.pop_front();
      checks++; if (bp.pc_out !== e.pc) begin errors++; $display("FAIL beq_pc: got %h want %h", bp.pc_out, e.pc); end
      checks++; if (bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL beq_mis: got %b want %b", bp.branch_mispredicted_out, e.mis); end
      @(negedge clk);
      checks++; if (bp.branch_mispredicted_out !== 1'b0) begin errors++; $display("FAIL beq_pulse_width: got %b want 0", bp.branch_mispredicted_out); end
      checks++; if (bp.pc_out !== 32'h140) begin errors++; $display("FAIL beq_pc_hold: got %h want 00000140", bp.pc_out); end
      bp.fetch_pc_in = 32'h100; #1;
      checks++; if (bp.predict_taken_out !== 1'b1) begin errors++; $display("FAIL beq_lookup_taken: got %b want 1", bp.predict_taken_out); end
      checks++; if (bp.predict_target_out !== 32'h140) begin errors++; $display("FAIL beq_lookup_target: got %h want 00000140", bp.predict_target_out); end
   endtask

   // Counter 10 -> 11 -> 10 -> 01; prediction flips only on the second not-taken
   task automatic test_counter();
      logic [31:0] rs2v [3];
      logic        pt   [3];
      logic [31:0] epc  [3];
      logic        emis [3];
      logic        etk  [3];
      rs2v = '{32'd5, 32'd6, 32'd6};
      pt   = '{1'b1, 1'b1, 1'b1};
      epc  = '{32'h140, 32'h104, 32'h104};
      emis = '{1'b0, 1'b1, 1'b1};
      etk  = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         issue(7'h63, 3'd0, 32'h100, 32'd5, rs2v[i], 32'h40, pt[i], 32'h140);
         sb.push_back(mk(epc[i], emis[i]));
         @(negedge clk); idle();
         e = sb.pop_front();
         checks++; if (bp.pc_out !== e.pc) begin errors++; $display("FAIL counter_pc[%0d]: got %h want %h", i, bp.pc_out, e.pc); end
         checks++; if (bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL counter_mis[%0d]: got %b want %b", i, bp.branch_mispredicted_out, e.mis); end
         bp.fetch_pc_in = 32'h100; #1;
         checks++; if (bp.predict_taken_out !== etk[i]) begin errors++; $display("FAIL counter_lookup[%0d]: got %b want %b", i, bp.predict_taken_out, etk[i]); end
      end
      checks++; if (bp.predict_target_out !== 32'h140) begin errors++; $display("FAIL counter_hit_target: got %h want 00000140", bp.predict_target_out); end
   endtask

   // 0x1100 aliases 0x100: not-taken leaves the entry, taken replaces it
   task automatic test_alias();
      @(negedge clk);
      issue(7'h63, 3'd1, 32'h1100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
      sb.push_back(mk(32'h1104, 1'b0));
      @(negedge clk); idle();
      e = sb.pop_front();
      checks++; if (bp.pc_out !== e.pc || bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL alias_nt: got %h/%b want %h/%b", bp.pc_out, bp.branch_mispredicted_out, e.pc, e.mis); end
      bp.fetch_pc_in = 32'h100; #1;
      checks++; if (bp.predict_target_out !== 32'h140) begin errors++; $display("FAIL alias_untouched: got %h want 00000140", bp.predict_target_out); end
      @(negedge clk);
      issue(7'h63, 3'd0, 32'h1100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
      sb.push_back(mk(32'h1120, 1'b1));
      @(negedge clk); idle();
      e = sb.pop_front();
      checks++; if (bp.pc_out !== e.pc || bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL alias_tk: got %h/%b want %h/%b", bp.pc_out, bp.branch_mispredicted_out, e.pc, e.mis); end
      bp.fetch_pc_in = 32'h1100; #1;
      checks++; if (bp.predict_taken_out !== 1'b1 || bp.predict_target_out !== 32'h1120) begin errors++; $display("FAIL alias_new_owner: got %b/%h want 1/00001120", bp.predict_taken_out, bp.predict_target_out); end
      bp.fetch_pc_in = 32'h100; #1;
      checks++; if (bp.predict_taken_out !== 1'b0 || bp.predict_target_out !== 32'h104) begin errors++; $display("FAIL alias_old_evicted: got %b/%h want 0/00000104", bp.predict_taken_out, bp.predict_target_out); end
   endtask

   task automatic test_signed_unsigned();
      logic [2:0]  f3  [4];
      logic [31:0] pcs [4];
      logic [31:0] epc [4];
      logic        em  [4];
      f3  = '{3'd4, 3'd6, 3'd5, 3'd7};
      pcs = '{32'h204, 32'h208, 32'h20C, 32'h210};
      epc = '{32'h214, 32'h20C, 32'h210, 32'h220};
      em  = '{1'b1, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         issue(7'h63, f3[i], pcs[i], 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
         sb.push_back(mk(epc[i], em[i]));
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (bp.pc_out !== e.pc) begin errors++; $display("FAIL cmp_pc[f3=%0d]: got %h want %h", f3[i], bp.pc_out, e.pc); end
         checks++; if (bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL cmp_mis[f3=%0d]: got %b want %b", f3[i], bp.branch_mispredicted_out, e.mis); end
      end
      idle();
   endtask

   task automatic test_jalr();
      logic [31:0] ptg [2];
      logic        em  [2];
      ptg = '{32'h2002, 32'h3000};
      em  = '{1'b0, 1'b1};
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         issue(7'h67, 3'd0, 32'h404, 32'h2001, 32'd0, 32'd2, 1'b1, ptg[i]);
         sb.push_back(mk(32'h2002, em[i]));
         @(negedge clk);
         e = sb.pop_front();
         checks++; if (bp.pc_out !== e.pc) begin errors++; $display("FAIL jalr_pc[%0d]: got %h want %h", i, bp.pc_out, e.pc); end
         checks++; if (bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL jalr_mis[%0d]: got %b want %b", i, bp.branch_mispredicted_out, e.mis); end
      end
      idle();
      bp.fetch_pc_in = 32'h404; #1;
      checks++; if (bp.predict_taken_out !== 1'b1 || bp.predict_target_out !== 32'h2002) begin errors++; $display("FAIL jalr_lookup: got %b/%h want 1/00002002", bp.predict_taken_out, bp.predict_target_out); end
   endtask

   task automatic test_jal_stale();
      @(negedge clk);
      issue(7'h6f, 3'd0, 32'h508, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0);
      sb.push_back(mk(32'h500, 1'b1));
      @(negedge clk); idle();
      e = sb.pop_front();
      checks++; if (bp.pc_out !== e.pc || bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL jal: got %h/%b want %h/%b", bp.pc_out, bp.branch_mispredicted_out, e.pc, e.mis); end
      bp.fetch_pc_in = 32'h508; #1;
      checks++; if (bp.predict_taken_out !== 1'b1 || bp.predict_target_out !== 32'h500) begin errors++; $display("FAIL jal_lookup: got %b/%h want 1/00000500", bp.predict_taken_out, bp.predict_target_out); end
      @(negedge clk);
      issue(7'h33, 3'd0, 32'h508, 32'h0, 32'h0, 32'h0, 1'b1, 32'h500);
      sb.push_back(mk(32'h50C, 1'b1));
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bp.pc_out !== e.pc || bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL stale: got %h/%b want %h/%b", bp.pc_out, bp.branch_mispredicted_out, e.pc, e.mis); end
      issue(7'h33, 3'd0, 32'h508, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      sb.push_back(mk(32'h50C, 1'b0));
      @(negedge clk); idle();
      e = sb.pop_front();
      checks++; if (bp.pc_out !== e.pc || bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL other_nopred: got %h/%b want %h/%b", bp.pc_out, bp.branch_mispredicted_out, e.pc, e.mis); end
      bp.fetch_pc_in = 32'h508; #1;
      checks++; if (bp.predict_taken_out !== 1'b0 || bp.predict_target_out !== 32'h50C) begin errors++; $display("FAIL stale_lookup: got %b/%h want 0/0000050c", bp.predict_taken_out, bp.predict_target_out); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [8];
      logic [31:0] b [8];
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] pc, imm, ptgt;
      logic        pt;
      int          n;
      a = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF};
      b = '{32'd5, 32'd6, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
      n = 18;
      @(negedge clk);
      for (int k = 0; k <= n; k++) begin
         if (k > 0) begin
            e = sb.pop_front();
            checks++; if (bp.pc_out !== e.pc || bp.branch_mispredicted_out !== e.mis) begin errors++; $display("FAIL b2b[%0d]: got %h/%b want %h/%b", k-1, bp.pc_out, bp.branch_mispredicted_out, e.pc, e.mis); end
         end
         if (k < n) begin
            op   = (k == 16) ? 7'h6f : (k == 17) ? 7'h67 : 7'h63;
            f3   = 3'(k % 8);
            pc   = 32'h1040 + 32'(4 * k);
            imm  = (k % 2 == 1) ? 32'hFFFF_FFF0 : 32'h20;
            pt   = 1'($urandom_range(0, 1));
            ptgt = (k % 3 == 0) ? pc + imm + 32'd4 : pc + imm;
            issue(op, f3, pc, a[(k * 3) % 8], b[(k * 3) % 8], imm, pt, ptgt);
            sb.push_back(model(op, f3, pc, a[(k * 3) % 8], b[(k * 3) % 8], imm, pt, ptgt));
            @(negedge clk);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      issue(7'h63, 3'd0, 32'h60C, 32'd1, 32'd1, 32'h80, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      idle();
      @(negedge clk);
      checks++; if (bp.branch_mispredicted_out !== 1'b0 || bp.pc_out !== 32'h0) begin errors++; $display("FAIL rst_mid: got %b/%h want 0/00000000", bp.branch_mispredicted_out, bp.pc_out); end
      issue(7'h63, 3'd0, 32'h60C, 32'd1, 32'd1, 32'h80, 1'b0, 32'h0);
      @(negedge clk);
      checks++; if (bp.branch_mispredicted_out !== 1'b0 || bp.pc_out !== 32'h0) begin errors++; $display("FAIL rst_ignores_exec: got %b/%h want 0/00000000", bp.branch_mispredicted_out, bp.pc_out); end
      reset = 1'b0;
      idle();
      sb.delete();
      @(negedge clk);
      checks++; if (bp.branch_mispredicted_out !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got %b want 0", bp.branch_mispredicted_out); end
      bp.fetch_pc_in = 32'h60C; #1;
      checks++; if (bp.predict_taken_out !== 1'b0 || bp.predict_target_out !== 32'h610) begin errors++; $display("FAIL rst_tbl_60c: got %b/%h want 0/00000610", bp.predict_taken_out, bp.predict_target_out); end
      bp.fetch_pc_in = 32'h404; #1;
      checks++; if (bp.predict_taken_out !== 1'b0 || bp.predict_target_out !== 32'h408) begin errors++; $display("FAIL rst_tbl_404: got %b/%h want 0/00000408", bp.predict_taken_out, bp.predict_target_out); end
      bp.fetch_pc_in = 32'h1100; #1;
      checks++; if (bp.predict_taken_out !== 1'b0 || bp.predict_target_out !== 32'h1104) begin errors++; $display("FAIL rst_tbl_1100: got %b/%h want 0/00001104", bp.predict_taken_out, bp.predict_target_out); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_counter();
      test_alias();
      test_signed_unsigned();
      test_jalr();
      test_jal_stale();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
